// File: rtl/dcr_host_regs.sv
// dcr_host_regs: DCR register slave for the SATA host controller.
//   Decodes DCR_ABus[0:4] against C_DCR_BASE and passes the bus through when
//   not selected. A held-ack FSM runs one register access per transaction.
//   Holds ring setup, host-owned indices, the interrupt status/enable and
//   per-port error request/ack handshakes.
// Ports:
//   sys_clk/sys_rst          clock, async active-high reset
//   DCR_Read/Write/ABus/Sl_DBus  DCR request side; Sl_dcrDBus/Sl_dcrAck reply
//   interrupt, soft_rst, ring_enable, DBG_STOP   control outputs
//   inband_*/outband_*       ring base/addr/index registers and engine indices
//   err_req/err_req_vld, err_ack/err_ack_vld      per-port error handshake
//   dma_state, npi_ict_state debug status (read only)
// Optional feature: define DCR_HOST_IRQ_COALESCE_EN to compile in the
//   interrupt coalescing timer on IRQSTAT bit0 (COALESCE register at 0x03).
module dcr_host_regs #(
   parameter int         C_NUM_PORTS   = 4,
   parameter int         C_IDX_W       = 12,
   parameter logic [4:0] C_DCR_BASE    = 5'h0,
   parameter int         C_RST_STRETCH = 32
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic                       DCR_Read,
   input  logic                       DCR_Write,
   input  logic [0:9]                 DCR_ABus,
   input  logic [0:31]                DCR_Sl_DBus,
   output logic [0:31]                Sl_dcrDBus,
   output logic                       Sl_dcrAck,
   output logic                       interrupt,
   output logic                       soft_rst,
   output logic                       ring_enable,
   output logic                       DBG_STOP,
   output logic [31:0]                inband_base,
   output logic [31:0]                inband_cons_addr,
   output logic [31:0]                outband_base,
   output logic [31:0]                outband_prod_addr,
   output logic [C_IDX_W-1:0]         inband_prod_index,
   output logic [C_IDX_W-1:0]         outband_cons_index,
   input  logic [C_IDX_W-1:0]         inband_cons_index,
   input  logic [C_IDX_W-1:0]         outband_prod_index,
   output logic [8*C_NUM_PORTS-1:0]   err_req,
   output logic [C_NUM_PORTS-1:0]     err_req_vld,
   input  logic [8*C_NUM_PORTS-1:0]   err_ack,
   input  logic [C_NUM_PORTS-1:0]     err_ack_vld,
   input  logic [32*C_NUM_PORTS-1:0]  dma_state,
   input  logic [31:0]                npi_ict_state
);
   localparam int NP = C_NUM_PORTS;
   localparam int IW = C_IDX_W;

   typedef enum logic {S_IDLE, S_ACK} state_t;

   logic        sel, req;
   logic [4:0]  reg_a;
   logic [31:0] wdata, rd_mux, irq_stat, irq_src;

   assign sel   = (DCR_ABus[0:4] == C_DCR_BASE);
   assign req   = DCR_Read | DCR_Write;
   assign reg_a = DCR_ABus[5:9];
   assign wdata = DCR_Sl_DBus;

   // ---------------- ack FSM and access capture ----------------
   state_t      state_q;
   logic        ack_q, rd_q, wr_pend_q;
   logic [4:0]  waddr_q;
   logic [31:0] rdata_q, wdata_q;

   // Read data is captured on entry to ACK and held for the whole handshake;
   // the write is committed one cycle later from the captured address/data.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= S_IDLE;
         ack_q     <= 1'b0;
         rd_q      <= 1'b0;
         rdata_q   <= '0;
         wr_pend_q <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         wr_pend_q <= 1'b0;
         case (state_q)
            S_IDLE: if (sel && req) begin
               state_q   <= S_ACK;
               ack_q     <= 1'b1;
               rd_q      <= DCR_Read;
               rdata_q   <= rd_mux;
               wr_pend_q <= DCR_Write;
               waddr_q   <= reg_a;
               wdata_q   <= wdata;
            end
            S_ACK: if (!req) begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
               rd_q    <= 1'b0;
            end
         endcase
      end
   end

   assign Sl_dcrAck  = ack_q;
   assign Sl_dcrDBus = (sel && ack_q && rd_q) ? rdata_q : DCR_Sl_DBus;

   // ---------------- register file ----------------
   logic              ring_en_q, ring_en_d, dbg_q, dbg_d, irq_q, irq_d;
   logic [31:0]       rst_cnt_q, rst_cnt_d, irqen_q, irqen_d;
   logic [31:0]       ib_base_q, ib_base_d, ib_caddr_q, ib_caddr_d;
   logic [31:0]       ob_base_q, ob_base_d, ob_paddr_q, ob_paddr_d;
   logic [IW-1:0]     ib_pidx_q, ib_pidx_d, ob_cidx_q, ob_cidx_d;
   logic [NP-1:0]     sticky_q, sticky_d, vld_q, vld_d;
   logic [NP-1:0][7:0] code_q, code_d, ack_code_q, ack_code_d;
   logic              ob_neq;
   logic [IW-1:0]     depth;

   assign ob_neq = (outband_prod_index != ob_cidx_q);
   assign depth  = outband_prod_index - ob_cidx_q;

`ifdef DCR_HOST_IRQ_COALESCE_EN
   logic [7:0]  thresh_q, thresh_d;
   logic [15:0] tmo_q, tmo_d, timer_q, timer_d;
   logic        coal_ok;
   // Zero disables a criterion; with both disabled bit0 passes immediately.
   assign coal_ok = ((thresh_q == 8'd0) && (tmo_q == 16'd0)) ||
                    ((thresh_q != 8'd0) && (32'(depth) >= 32'(thresh_q))) ||
                    ((tmo_q != 16'd0) && (timer_q >= tmo_q));
`endif

   always_comb begin
      irq_stat         = '0;
      irq_stat[0]      = ob_neq;
      irq_stat[1]      = (ib_pidx_q == inband_cons_index);
      irq_stat[8 +: NP] = sticky_q;
      irq_src          = irq_stat;
`ifdef DCR_HOST_IRQ_COALESCE_EN
      irq_src[0]       = ob_neq & coal_ok;
`endif
   end

   always_comb begin
      rd_mux = '0;
      case (reg_a)
         5'h00: rd_mux = irq_stat;
         5'h01: rd_mux = irqen_q;
         5'h02: rd_mux = {29'h0, dbg_q, soft_rst, ring_en_q};
`ifdef DCR_HOST_IRQ_COALESCE_EN
         5'h03: rd_mux = {8'h0, thresh_q, tmo_q};
`endif
         5'h04: rd_mux = ib_base_q;
         5'h05: rd_mux = ib_caddr_q;
         5'h06: rd_mux = 32'(ib_pidx_q);
         5'h07: rd_mux = 32'(inband_cons_index);
         5'h08: rd_mux = ob_base_q;
         5'h09: rd_mux = ob_paddr_q;
         5'h0a: rd_mux = 32'(ob_cidx_q);
         5'h0b: rd_mux = 32'(outband_prod_index);
         5'h1f: rd_mux = npi_ict_state;
         default: rd_mux = '0;
      endcase
      for (int p = 0; p < NP; p++) begin
         if (reg_a == 5'(12 + p)) rd_mux = {16'h0, ack_code_q[p], 7'h0, vld_q[p]};
         if (reg_a == 5'(20 + p)) rd_mux = dma_state[32*p +: 32];
      end
   end

   always_comb begin
      ring_en_d  = ring_en_q;
      dbg_d      = dbg_q;
      rst_cnt_d  = (rst_cnt_q != 32'd0) ? rst_cnt_q - 32'd1 : 32'd0;
      irqen_d    = irqen_q;
      ib_base_d  = ib_base_q;
      ib_caddr_d = ib_caddr_q;
      ob_base_d  = ob_base_q;
      ob_paddr_d = ob_paddr_q;
      ib_pidx_d  = ib_pidx_q;
      ob_cidx_d  = ob_cidx_q;
      sticky_d   = sticky_q;
      vld_d      = vld_q;
      code_d     = code_q;
      ack_code_d = ack_code_q;
      irq_d      = |(irqen_q & irq_src);
`ifdef DCR_HOST_IRQ_COALESCE_EN
      thresh_d   = thresh_q;
      tmo_d      = tmo_q;
      // Timer runs while bit0 is up, saturating, and restarts when it drops.
      timer_d    = !ob_neq ? 16'd0 : (timer_q == 16'hffff) ? timer_q : timer_q + 16'd1;
`endif
      if (wr_pend_q) begin
         case (waddr_q)
            5'h00: sticky_d = sticky_q & ~wdata_q[8 +: NP];
            5'h01: irqen_d = wdata_q;
            5'h02: begin
               ring_en_d = wdata_q[0];
               dbg_d     = wdata_q[2];
               if (wdata_q[1]) rst_cnt_d = 32'(C_RST_STRETCH);
            end
`ifdef DCR_HOST_IRQ_COALESCE_EN
            5'h03: begin
               thresh_d = wdata_q[23:16];
               tmo_d    = wdata_q[15:0];
            end
`endif
            // Ring addresses are frozen while the engines own the rings.
            5'h04: if (!ring_en_q) ib_base_d  = wdata_q;
            5'h05: if (!ring_en_q) ib_caddr_d = wdata_q;
            5'h06: ib_pidx_d = wdata_q[IW-1:0];
            5'h08: if (!ring_en_q) ob_base_d  = wdata_q;
            5'h09: if (!ring_en_q) ob_paddr_d = wdata_q;
            5'h0a: ob_cidx_d = wdata_q[IW-1:0];
            default: ;
         endcase
         for (int p = 0; p < NP; p++)
            if ((waddr_q == 5'(12 + p)) && !vld_q[p]) begin
               code_d[p] = wdata_q[7:0];
               vld_d[p]  = 1'b1;
            end
      end
      // Ack handling comes last so a completing port's sticky bit beats a W1C.
      for (int p = 0; p < NP; p++)
         if (err_ack_vld[p]) begin
            vld_d[p]      = 1'b0;
            ack_code_d[p] = err_ack[8*p +: 8];
            sticky_d[p]   = 1'b1;
         end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ring_en_q  <= 1'b0;
         dbg_q      <= 1'b0;
         irq_q      <= 1'b0;
         rst_cnt_q  <= '0;
         irqen_q    <= '0;
         ib_base_q  <= '0;
         ib_caddr_q <= '0;
         ob_base_q  <= '0;
         ob_paddr_q <= '0;
         ib_pidx_q  <= '0;
         ob_cidx_q  <= '0;
         sticky_q   <= '0;
         vld_q      <= '0;
         code_q     <= '0;
         ack_code_q <= '0;
`ifdef DCR_HOST_IRQ_COALESCE_EN
         thresh_q   <= '0;
         tmo_q      <= '0;
         timer_q    <= '0;
`endif
      end else begin
         ring_en_q  <= ring_en_d;
         dbg_q      <= dbg_d;
         irq_q      <= irq_d;
         rst_cnt_q  <= rst_cnt_d;
         irqen_q    <= irqen_d;
         ib_base_q  <= ib_base_d;
         ib_caddr_q <= ib_caddr_d;
         ob_base_q  <= ob_base_d;
         ob_paddr_q <= ob_paddr_d;
         ib_pidx_q  <= ib_pidx_d;
         ob_cidx_q  <= ob_cidx_d;
         sticky_q   <= sticky_d;
         vld_q      <= vld_d;
         code_q     <= code_d;
         ack_code_q <= ack_code_d;
`ifdef DCR_HOST_IRQ_COALESCE_EN
         thresh_q   <= thresh_d;
         tmo_q      <= tmo_d;
         timer_q    <= timer_d;
`endif
      end
   end

   assign interrupt          = irq_q;
   assign soft_rst           = (rst_cnt_q != 32'd0);
   assign ring_enable        = ring_en_q;
   assign DBG_STOP           = dbg_q;
   assign inband_base        = ib_base_q;
   assign inband_cons_addr   = ib_caddr_q;
   assign outband_base       = ob_base_q;
   assign outband_prod_addr  = ob_paddr_q;
   assign inband_prod_index  = ib_pidx_q;
   assign outband_cons_index = ob_cidx_q;
   assign err_req            = code_q;
   assign err_req_vld        = vld_q;

endmodule

// File: tb/tb_dcr_host_regs.sv
// Directed bench for dcr_host_regs with default parameters (4 ports, 12-bit
// indices, base 0, 32-cycle soft reset). Inputs are driven 1 time unit after
// the rising edge and outputs are sampled at the same point.
module tb_dcr_host_regs;
   logic          clk = 1'b0, rst;
   logic          rd, wr;
   logic [0:9]    abus;
   logic [0:31]   dbus, sl_dbus;
   logic          ack, irq, srst, ring_en, dbg;
   logic [31:0]   ib_base, ib_caddr, ob_base, ob_paddr;
   logic [11:0]   ib_pidx, ob_cidx, ib_cidx, ob_pidx;
   logic [31:0]   err_req, err_ack;
   logic [3:0]    err_vld, err_ack_vld;
   logic [127:0]  dma_state;
   logic [31:0]   npi;
   logic [31:0]   rdat;
   int            errors = 0, checks = 0, n;

   dcr_host_regs dut (
      .sys_clk(clk), .sys_rst(rst), .DCR_Read(rd), .DCR_Write(wr),
      .DCR_ABus(abus), .DCR_Sl_DBus(dbus), .Sl_dcrDBus(sl_dbus), .Sl_dcrAck(ack),
      .interrupt(irq), .soft_rst(srst), .ring_enable(ring_en), .DBG_STOP(dbg),
      .inband_base(ib_base), .inband_cons_addr(ib_caddr), .outband_base(ob_base),
      .outband_prod_addr(ob_paddr), .inband_prod_index(ib_pidx),
      .outband_cons_index(ob_cidx), .inband_cons_index(ib_cidx),
      .outband_prod_index(ob_pidx), .err_req(err_req), .err_req_vld(err_vld),
      .err_ack(err_ack), .err_ack_vld(err_ack_vld), .dma_state(dma_state),
      .npi_ict_state(npi));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic dcr_write(input logic [4:0] a, input logic [31:0] d);
      abus = {5'h0, a}; dbus = d; wr = 1'b1;
      tick(); tick();
      wr = 1'b0;
      tick();
   endtask

   task automatic dcr_read(input logic [4:0] a, output logic [31:0] d);
      abus = {5'h0, a}; rd = 1'b1;
      tick();
      d = sl_dbus;
      rd = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; rd = 1'b0; wr = 1'b0; abus = '0; dbus = 32'h1234_5678;
      ib_cidx = '0; ob_pidx = '0; err_ack = '0; err_ack_vld = '0;
      dma_state = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
      npi = 32'hCAFE_F00D;
      tick(); tick();
      chk("rst_dbus_pass", sl_dbus, 32'h1234_5678);
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_ctrl", {28'h0, irq, srst, ring_en, dbg}, 32'h0);
      chk("rst_err_vld", {28'h0, err_vld}, 32'h0);
      chk("rst_ib_base", ib_base, 32'h0);
      rst = 1'b0;
      tick();

      // CTRL: ring_enable + DBG_STOP, then held 5-cycle read
      dcr_write(5'h02, 32'h5);
      chk("ctrl_outs", {30'h0, dbg, ring_en}, 32'h3);
      abus = {5'h0, 5'h02}; rd = 1'b1;
      chk("held_ack_pre", {31'h0, ack}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("held_ack", {31'h0, ack}, 32'h1);
         chk("held_data", sl_dbus, 32'h5);
      end
      rd = 1'b0;
      tick();
      chk("held_ack_fall", {31'h0, ack}, 32'h0);

      // base mismatch: no ack, data passes through
      abus = {5'h1, 5'h02}; dbus = 32'hA5A5_A5A5; rd = 1'b1;
      tick(); tick();
      chk("nosel_ack", {31'h0, ack}, 32'h0);
      chk("nosel_dbus", sl_dbus, 32'hA5A5_A5A5);
      rd = 1'b0;
      tick();

      // ring base write lockout
      dcr_write(5'h04, 32'h1234_0000);
      chk("base_locked", ib_base, 32'h0);
      dcr_write(5'h02, 32'h0);
      chk("ctrl_clear", {30'h0, dbg, ring_en}, 32'h0);
      dcr_write(5'h04, 32'h1234_0000);
      chk("base_written", ib_base, 32'h1234_0000);
      dcr_write(5'h09, 32'h0BAD_0010);
      chk("ob_paddr", ob_paddr, 32'h0BAD_0010);

      // outband level interrupt
      dcr_write(5'h01, 32'h1);
      chk("irq_idle", {31'h0, irq}, 32'h0);
      ob_pidx = 12'hFFF;
      chk("irq_same_cycle", {31'h0, irq}, 32'h0);
      tick();
      chk("irq_next_cycle", {31'h0, irq}, 32'h1);
      dcr_write(5'h0a, 32'h001);
      dcr_read(5'h00, rdat);
      chk("irqstat_levels", rdat, 32'h3);
      dcr_read(5'h0b, rdat);
      chk("ob_prod_ro", rdat, 32'hFFF);
      dcr_write(5'h0a, 32'hFFF);
      chk("ob_cons_out", {20'h0, ob_cidx}, 32'hFFF);
      chk("irq_deassert", {31'h0, irq}, 32'h0);

      // ERR[2] request/ack handshake
      abus = {5'h0, 5'h0e}; dbus = 32'h5A; wr = 1'b1;
      tick();
      chk("err_ack_rise", {31'h0, ack}, 32'h1);
      chk("err_vld_pre", {28'h0, err_vld}, 32'h0);
      tick();
      chk("err_vld_set", {28'h0, err_vld}, 32'h4);
      chk("err_code", {24'h0, err_req[23:16]}, 32'h5A);
      wr = 1'b0;
      tick();
      dcr_write(5'h0e, 32'h11);
      chk("err_rewrite_ign", {24'h0, err_req[23:16]}, 32'h5A);
      err_ack = 32'h003C_0000; err_ack_vld = 4'b0100;
      tick();
      chk("err_vld_clr", {28'h0, err_vld}, 32'h0);
      err_ack = '0; err_ack_vld = '0;
      dcr_read(5'h00, rdat);
      chk("irqstat_sticky", rdat, 32'h402);
      dcr_read(5'h0e, rdat);
      chk("err_readback", rdat, 32'h3C00);
      dcr_write(5'h00, 32'h400);
      dcr_read(5'h00, rdat);
      chk("irqstat_w1c", rdat, 32'h2);

      // soft reset stretch
      abus = {5'h0, 5'h02}; dbus = 32'h2; wr = 1'b1;
      tick();
      chk("srst_pre", {31'h0, srst}, 32'h0);
      tick();
      wr = 1'b0;
      chk("srst_start", {31'h0, srst}, 32'h1);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (srst) n++;
         tick();
      end
      chk("srst_len", 32'(n), 32'd32);

      // index width, status reads, absent/unmapped registers
      dcr_write(5'h06, 32'h000A_BCDE);
      chk("ib_pidx_trunc", {20'h0, ib_pidx}, 32'hCDE);
      dcr_read(5'h15, rdat);
      chk("dma_state1", rdat, 32'hD000_0001);
      dcr_read(5'h1f, rdat);
      chk("npi_state", rdat, 32'hCAFE_F00D);
      dcr_read(5'h18, rdat);
      chk("absent_port", rdat, 32'h0);
      dcr_read(5'h1c, rdat);
      chk("unmapped", rdat, 32'h0);

`ifdef DCR_HOST_IRQ_COALESCE_EN
      // thresh=4, timeout=100; cons=0xFFF, prod 0x000 gives depth 1
      dcr_write(5'h03, 32'h0004_0064);
      dcr_read(5'h03, rdat);
      chk("coal_readback", rdat, 32'h0004_0064);
      ob_pidx = 12'h000;
      for (int i = 0; i < 100; i++) tick();
      chk("coal_timer_hold", {31'h0, irq}, 32'h0);
      tick();
      chk("coal_timer_fire", {31'h0, irq}, 32'h1);
      ob_pidx = 12'hFFF;
      tick();
      chk("coal_drop", {31'h0, irq}, 32'h0);
      ob_pidx = 12'h003;
      tick();
      chk("coal_depth_fire", {31'h0, irq}, 32'h1);
      ob_pidx = 12'hFFF;
      tick();
`else
      dcr_write(5'h03, 32'h0004_0064);
      dcr_read(5'h03, rdat);
      chk("coal_absent", rdat, 32'h0);
`endif

      // reset in the middle of a held transaction
      dcr_write(5'h0d, 32'h77);
      chk("err1_vld", {28'h0, err_vld}, 32'h2);
      abus = {5'h0, 5'h00}; rd = 1'b1;
      tick();
      chk("mid_ack", {31'h0, ack}, 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ack", {31'h0, ack}, 32'h0);
      chk("mid_rst_vld", {28'h0, err_vld}, 32'h0);
      chk("mid_rst_req", err_req, 32'h0);
      rd = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_ack", {31'h0, ack}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
